// File: rtl/apb_pkg.sv
// Shared APB types: FSM state encoding, default bus widths and the
// command bundle carried from the command port onto the APB bus.
package apb_pkg;

  localparam int APB_ADDR_W = 10;
  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_t;

  typedef struct packed {
    logic                  write;
    logic [APB_ADDR_W-1:0] addr;
    logic [APB_DATA_W-1:0] data;
  } apb_cmd_t;

endpackage

// File: rtl/apb_cmd_master.sv
// APB requester: turns one valid/ready command into an APB SETUP/ACCESS
// transfer and returns exactly one response per command. A saturating
// wait-state counter aborts transfers whose slave never raises pready.
// The command bundle uses the package struct, so ADDR_W/DATA_W are
// expected to stay at the package default widths.
module apb_cmd_master
  import apb_pkg::*;
#(
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_write_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [DATA_W-1:0] cmd_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              psel_o,
  output logic              penable_o,
  output logic              pwrite_o,
  output logic [ADDR_W-1:0] paddr_o,
  output logic [DATA_W-1:0] pwdata_o,
  input  logic [DATA_W-1:0] prdata_i,
  input  logic              pready_i
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  apb_state_t       state_reg;
  logic [CNT_W-1:0] wait_cnt_reg;
  logic [CNT_W-1:0] wait_cnt_next;
  apb_cmd_t         cmd_in;

  assign cmd_in = '{write: cmd_write_i, addr: cmd_addr_i, data: cmd_wdata_i};

  // Handshake flags come straight from the state register; ready is masked
  // while reset is held so nothing looks acceptable during reset.
  assign cmd_ready_o = (state_reg == IDLE) && !reset;
  assign rsp_valid_o = (state_reg == RESP);

  // Saturating increment: the counter parks at TIMEOUT instead of wrapping.
  always_comb begin
    wait_cnt_next = wait_cnt_reg;
    if (wait_cnt_reg != CNT_MAX) begin
      wait_cnt_next = wait_cnt_reg + CNT_W'(1);
    end
  end

  // Transfer FSM with all APB and response outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      wait_cnt_reg <= '0;
      psel_o       <= 1'b0;
      penable_o    <= 1'b0;
      pwrite_o     <= 1'b0;
      paddr_o      <= '0;
      pwdata_o     <= '0;
      rsp_rdata_o  <= '0;
      rsp_err_o    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (cmd_valid_i) begin
            state_reg    <= SETUP;
            wait_cnt_reg <= '0;
            psel_o       <= 1'b1;
            penable_o    <= 1'b0;
            pwrite_o     <= cmd_in.write;
            paddr_o      <= cmd_in.addr;
            pwdata_o     <= cmd_in.data;
          end
        end
        SETUP: begin
          state_reg    <= ACCESS;
          wait_cnt_reg <= '0;
          penable_o    <= 1'b1;
        end
        ACCESS: begin
          if (pready_i) begin
            // A ready slave wins even on the edge the timeout would fire.
            state_reg   <= RESP;
            rsp_rdata_o <= pwrite_o ? '0 : prdata_i;
            rsp_err_o   <= 1'b0;
            psel_o      <= 1'b0;
            penable_o   <= 1'b0;
            pwrite_o    <= 1'b0;
            paddr_o     <= '0;
            pwdata_o    <= '0;
          end else begin
            wait_cnt_reg <= wait_cnt_next;
            if (wait_cnt_next == CNT_MAX) begin
              state_reg   <= RESP;
              rsp_rdata_o <= '0;
              rsp_err_o   <= 1'b1;
              psel_o      <= 1'b0;
              penable_o   <= 1'b0;
              pwrite_o    <= 1'b0;
              paddr_o     <= '0;
              pwdata_o    <= '0;
            end
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
